pe_column_normalizer: RTL and testbench

- Downstream stage of the DSP processing-element (PE) chain.
- Consumes the stream of 48-bit column sums out of the last PE and carry-propagates it into radix-2^K digits.
- Emits one K-bit digit per accepted column, then flushes the residual carry as a fixed number of extra digits.
- Its output digit stream feeds the result buffer or the next reduction pass.

---
 rtl/pe_column_normalizer.sv | 122 ++++++++++++
 tb/tb_pe_column_normalizer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_column_normalizer.sv
// pe_column_normalizer: carry-propagates PE column sums into K-bit digits, then flushes the residual carry.
// Optional column-count check enabled by defining NORM_COUNT_CHECK_EN.
module pe_column_normalizer #(
    parameter int K      = 16,
    parameter int N_COLS = 32,
    parameter int SW     = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_s,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_digit,
    output logic          out_last,
    output logic          err
);
    localparam int CW = SW + 1 - K;
    localparam int NF = (CW + K - 1) / K;
    localparam int FW = $clog2(NF + 1);

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] carry_q, carry_d;
    logic          out_valid_q, out_valid_d;
    logic [K-1:0]  out_digit_q, out_digit_d;
    logic          out_last_q, out_last_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [SW:0]   sum;
    logic          free, accept, flush_end;

    assign free      = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ACCUM) && free;
    assign accept    = in_valid && in_ready;
    assign sum       = {1'b0, in_s} + (SW+1)'(carry_q);
    assign flush_end = fcnt_q == FW'(NF - 1);

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_last_d  = out_last_q;
        fcnt_d      = fcnt_q;
        if (accept) begin
            out_digit_d = sum[K-1:0];
            carry_d     = sum[SW:K];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            state_d     = in_last ? FLUSH : ACCUM;
            fcnt_d      = in_last ? '0 : fcnt_q;
        end else if (state_q == FLUSH && free) begin
            out_digit_d = carry_q[K-1:0];
            carry_d     = flush_end ? '0 : carry_q >> K;
            fcnt_d      = fcnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_last_d  = flush_end;
            state_d     = flush_end ? ACCUM : FLUSH;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_last_q  <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_last_q  <= out_last_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_last  = out_last_q;

`ifdef NORM_COUNT_CHECK_EN
    localparam int CCW = $clog2(N_COLS + 1);

    logic [CCW-1:0] ccnt_q, ccnt_d;
    logic           err_q, err_d;

    // Counter saturates at N_COLS; any column beyond that is already an error.
    always_comb begin
        ccnt_d = ccnt_q;
        err_d  = err_q;
        if (accept && in_last) begin
            err_d  = err_q | (int'(ccnt_q) + 1 != N_COLS);
            ccnt_d = '0;
        end else if (accept) begin
            err_d  = err_q | (int'(ccnt_q) + 1 > N_COLS);
            ccnt_d = (int'(ccnt_q) < N_COLS) ? ccnt_q + 1'b1 : ccnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ccnt_q <= ccnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0 & (N_COLS < 0);
`endif
endmodule

// File: tb/tb_pe_column_normalizer.sv
// tb_pe_column_normalizer: directed and randomized checks against a big-integer digit-expansion model.
module tb_pe_column_normalizer;
    localparam int K  = 16;
    localparam int SW = 48;
    localparam int NF = 3;
`ifdef NORM_COUNT_CHECK_EN
    localparam int NC = 2;
`else
    localparam int NC = 32;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_s = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [K-1:0]  out_digit;
    logic          out_last;
    logic          err;

    pe_column_normalizer #(.K(K), .N_COLS(NC), .SW(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_digit(out_digit), .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [K:0] exp_q[$];
    bit rnd_bp = 1'b0;

    // Operation value = sum of col_i * 2^(K*i); its radix-2^K expansion is the digit stream.
    function automatic void push_op(input logic [SW-1:0] cols[$]);
        logic [255:0] v = '0;
        int n = cols.size() + NF;
        for (int i = 0; i < cols.size(); i++) v += 256'(cols[i]) << (K * i);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back({j == n - 1, v[K-1:0]});
            v = v >> K;
        end
    endfunction

    always begin
        @(negedge clk);
        #4;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL digit_unexpected got last=%b digit=%h, none expected", out_last, out_digit);
            end else begin
                logic [K:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_digit} !== e) begin
                    errors++;
                    $display("FAIL digit got last=%b digit=%h exp last=%b digit=%h",
                             out_last, out_digit, e[K], e[K-1:0]);
                end
            end
        end
    end

    always begin
        @(negedge clk);
        if (rnd_bp) out_ready = ($urandom % 4) != 0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_op(input logic [SW-1:0] cols[$], output int waits);
        waits = 0;
        push_op(cols);
        for (int i = 0; i < cols.size(); i++) begin
            bit acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_s = cols[i];
                in_last = (i == cols.size() - 1);
                #1;
                acc = in_ready;
                if (!acc) waits++;
                if (waits > 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout col=%0d in_ready=%b", i, in_ready);
                    return;
                end
                @(posedge clk);
            end
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain remaining=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_digit, out_last, err} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got valid=%b digit=%h last=%b err=%b ready=%b required 0,0,0,0,1",
                     out_valid, out_digit, out_last, err, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int w;
        out_ready = 1'b1;
        send_op('{48'h0000_0001_2345}, w);
        idle_in();
        drain("single");
`ifndef NORM_COUNT_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL single_err got=%b required=0", err);
        end
`endif
    endtask

    task automatic test_carry();
        int w;
        send_op('{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001}, w);
        idle_in();
        drain("carry");
    endtask

    task automatic test_backpressure();
        int w;
        fork
            send_op('{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001}, w);
            begin
                int t = 0;
                while (!out_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_digit !== 16'hFFFF || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cyc=%0d got valid=%b digit=%h ready=%b required 1,ffff,0",
                                 c, out_valid, out_digit, in_ready);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        idle_in();
        drain("backpressure");
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        out_ready = 1'b1;
        send_op('{48'h1}, w1);
        send_op('{48'h1}, w2);
        idle_in();
        checks++;
        if (w2 != NF) begin
            errors++;
            $display("FAIL b2b_ready_low got=%0d cycles required=%0d", w2, NF);
        end
        drain("back_to_back");
    endtask

    task automatic test_reset_midflush();
        int w;
        send_op('{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001}, w);
        idle_in();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({out_valid, out_digit, out_last, err} !== '0) begin
            errors++;
            $display("FAIL midflush_reset got valid=%b digit=%h last=%b err=%b required all 0",
                     out_valid, out_digit, out_last, err);
        end
        @(negedge clk);
        rst = 1'b0;
        send_op('{48'h0005}, w);
        idle_in();
        drain("after_reset");
    endtask

    task automatic test_random();
        int w;
        rnd_bp = 1'b1;
        for (int op = 0; op < 40; op++) begin
            logic [SW-1:0] cols[$];
            int n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                logic [63:0] r = {$urandom(), $urandom()};
                cols.push_back(($urandom % 3 == 0) ? '1 : r[SW-1:0]);
            end
            send_op(cols, w);
            if ($urandom % 2 == 0) idle_in();
        end
        idle_in();
        rnd_bp = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain("random");
    endtask

`ifdef NORM_COUNT_CHECK_EN
    task automatic test_count_check();
        int w;
        do_reset();
        send_op('{48'h1, 48'h2, 48'h3}, w);
        idle_in();
        drain("cnt3");
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL count_err3 got=%b required=1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL count_err_reset got=%b required=0", err);
        end
        send_op('{48'h7, 48'h8}, w);
        idle_in();
        drain("cnt2");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL count_err2 got=%b required=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_backpressure();
        test_back_to_back();
        test_reset_midflush();
        test_random();
`ifdef NORM_COUNT_CHECK_EN
        test_count_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
